des_key_sched_ctrl: RTL and testbench

Sequencer for the DES key schedule. It latches a 64-bit key and applies PC-1. It then steps through 16 rounds, applying the per-round C/D rotations and PC-2, and issues one 48-bit subkey per round over a valid/ready handshake to the round datapath. It supports encrypt order (K1..K16) and decrypt order (K16..K1), and sits between the key input register and the Feistel round engine.

---
 rtl/des_key_sched_ctrl.sv | 162 ++++++++++++++++
 tb/tb_des_key_sched_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule sequencer: latches a key, applies PC-1, then issues the 16
// PC-2 subkeys over a valid/ready handshake in encrypt or decrypt order.
module des_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int SUBKEY_W   = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                decrypt,
    input  logic [63:0]         key,
    output logic                busy,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          round,
    output logic                done,
    // FSM state for observation: 0=IDLE 1=LOAD 2=ISSUE 3=DONE
    output logic [1:0]          state_dbg
);

    // Handshake: a subkey transfers on any cycle with subkey_valid && subkey_ready;
    // while valid is high and ready is low, subkey and round hold stable.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    // FIPS 46-3 tables, 1-based bit numbers with bit 1 = MSB.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    // Left moves bits toward FIPS bit 1 (the MSB); right is the inverse.
    function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] amt,
                                          input logic right);
        logic [27:0] r;
        case ({right, amt})
            3'b0_01: r = {v[26:0], v[27]};
            3'b0_10: r = {v[25:0], v[27:26]};
            3'b1_01: r = {v[0], v[27:1]};
            3'b1_10: r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    state_t      state_q;
    logic [55:0] cd_q;
    logic [3:0]  round_q;
    logic        dec_q;

    logic [3:0]  next_idx;
    logic [1:0]  step_amt;
    logic [55:0] cd_d;
    logic [47:0] subkey_d;

    // Both orders share the same amounts except index 0, handled in LOAD.
    always_comb begin
        next_idx = round_q + 4'd1;
        step_amt = 2'd2;
        if (state_q == LOAD) begin
            step_amt = dec_q ? 2'd0 : 2'd1;
        end else if (next_idx == 4'd1 || next_idx == 4'd8 || next_idx == 4'd15) begin
            step_amt = 2'd1;
        end
        cd_d     = {rot28(cd_q[55:28], step_amt, dec_q), rot28(cd_q[27:0], step_amt, dec_q)};
        subkey_d = pc2(cd_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cd_q         <= '0;
            round_q      <= '0;
            dec_q        <= 1'b0;
            busy         <= 1'b0;
            subkey_valid <= 1'b0;
            subkey       <= '0;
            done         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dec_q   <= decrypt;
                        cd_q    <= pc1(key);
                        busy    <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    cd_q         <= cd_d;
                    subkey       <= subkey_d;
                    round_q      <= 4'd0;
                    subkey_valid <= 1'b1;
                    state_q      <= ISSUE;
                end
                ISSUE: begin
                    if (subkey_ready) begin
                        if (round_q == LAST_ROUND) begin
                            subkey_valid <= 1'b0;
                            done         <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            cd_q    <= cd_d;
                            subkey  <= subkey_d;
                            round_q <= next_idx;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign round     = round_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: directed and random schedules checked against
// a bit-indexed FIPS key-schedule model using cumulative shift counts.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        done;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    logic [47:0] exp_q[$];
    logic [47:0] model_ks [16];
    logic [47:0] got [16];

    localparam logic [63:0] K0 = 64'h133457799BBCDFF1;

    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_sched_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round        (round),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Encrypt-order subkeys K1..K16: round r uses C0/D0 shifted left by the running total.
    task automatic build_model(input logic [63:0] k);
        logic cd0 [1:56];
        int   tot;
        int   p;
        int   src;
        for (int n = 1; n <= 56; n++) cd0[n] = k[64 - T_PC1[n-1]];
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            model_ks[r] = '0;
            for (int m = 1; m <= 48; m++) begin
                p = T_PC2[m-1];
                if (p <= 28) src = ((p - 1 + tot) % 28) + 1;
                else         src = 28 + ((p - 29 + tot) % 28) + 1;
                model_ks[r][48-m] = cd0[src];
            end
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: 1010 toggle with a 5-cycle stall at round 7
    task automatic run_schedule(input logic [63:0] k, input bit dec, input int mode, input bit spam);
        int          hs;
        int          busy_cnt;
        int          first_v;
        int          last_hs;
        bit          done_seen;
        bit          held;
        int          hold_cnt;
        bit          tog;
        bit          r;
        bit          pv;
        bit          pr;
        logic [47:0] ps;
        logic [3:0]  pround;
        logic [47:0] e;

        build_model(k);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(dec ? model_ks[15-i] : model_ks[i]);
        for (int i = 0; i < 16; i++) got[i] = 'x;

        hs = 0; busy_cnt = 0; first_v = -1; last_hs = -1; done_seen = 0;
        held = 0; hold_cnt = 0; tog = 1; pv = 0; pr = 0; ps = '0; pround = '0;

        key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b0;
        tick();
        start   = spam;
        key     = spam ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
        decrypt = spam ? ~dec : 1'($urandom_range(0, 1));

        for (int cyc = 1; cyc < 400 && !done_seen; cyc++) begin
            if (pv && !pr) begin
                check("stall_valid", 64'(subkey_valid), 64'd1);
                check("stall_subkey", 64'(subkey), 64'(ps));
                check("stall_round", 64'(round), 64'(pround));
            end
            if (busy) busy_cnt++;
            if (subkey_valid && first_v < 0) first_v = cyc;
            if (done) begin
                done_seen = 1;
                check("done_latency", 64'(cyc), 64'(last_hs + 1));
                check("handshake_count", 64'(hs), 64'd16);
                check("done_valid_low", 64'(subkey_valid), 64'd0);
                check("done_busy_high", 64'(busy), 64'd1);
            end

            if (mode == 0) begin
                r = 1;
            end else if (mode == 1) begin
                r = ($urandom_range(0, 3) != 0);
            end else if (hold_cnt > 0) begin
                r = 0; hold_cnt--;
            end else if (subkey_valid && round == 4'd7 && !held) begin
                held = 1; hold_cnt = 4; r = 0;
            end else begin
                r = tog; tog = ~tog;
            end
            subkey_ready = r;

            if (subkey_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("extra_handshake", 64'(hs), 64'd16);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("subkey_hs%0d", hs), 64'(subkey), 64'(e));
                    check($sformatf("round_hs%0d", hs), 64'(round), 64'(hs % 16));
                    if (hs < 16) got[hs] = subkey;
                end
                last_hs = cyc;
                hs++;
            end
            pv = subkey_valid; pr = r; ps = subkey; pround = round;
            tick();
        end

        start = 1'b0; subkey_ready = 1'b0;
        check("done_seen", 64'(done_seen), 64'd1);
        check("first_valid_latency", 64'(first_v), 64'd2);
        if (mode == 0) check("busy_cycles", 64'(busy_cnt), 64'd18);
        check("post_done_pulse", 64'(done), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_state_idle", 64'(state_dbg), 64'd0);
        tick();
        check("idle_no_restart", 64'(busy), 64'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; subkey_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        rst = 1'b0;
        tick();

        run_schedule(K0, 1'b0, 0, 1'b0);
        check("enc_k1", 64'(got[0]), 64'h1B02EFFC7072);
        check("enc_k16", 64'(got[15]), 64'hCB3D8B0E17F5);

        run_schedule(K0, 1'b1, 0, 1'b0);
        check("dec_first", 64'(got[0]), 64'hCB3D8B0E17F5);
        check("dec_last", 64'(got[15]), 64'h1B02EFFC7072);

        run_schedule(K0, 1'b0, 2, 1'b0);
        run_schedule(K0, 1'b1, 2, 1'b0);
        run_schedule(K0, 1'b0, 0, 1'b1);

        // Reset in the middle of a schedule
        key = K0; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !(subkey_valid && round == 4'd5); i++) tick();
        check("reached_round5", 64'(round), 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(subkey_valid), 64'd0);
        check("midrst_subkey", 64'(subkey), 64'd0);
        check("midrst_round", 64'(round), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_state", 64'(state_dbg), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_quiet", 64'(subkey_valid), 64'd0);
        end
        subkey_ready = 1'b0;
        run_schedule(K0, 1'b0, 0, 1'b0);
        check("after_rst_k1", 64'(got[0]), 64'h1B02EFFC7072);

        run_schedule(64'h0101010101010101, 1'b0, 0, 1'b0);
        check("weak_k1", 64'(got[0]), 64'd0);
        check("weak_k9", 64'(got[8]), 64'd0);
        run_schedule(64'h0000000000000000, 1'b1, 1, 1'b0);
        check("zero_k16", 64'(got[15]), 64'd0);

        for (int t = 0; t < 6; t++) begin
            run_schedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
